word_burst_loader: RTL and testbench

- Upstream feeder for the multi-core top-level controller.
- Collects a serial byte stream from the host receiver into a local word buffer, assembling two bytes per 16-bit word.
- Once a full block is buffered and the controller is idle, replays the block one word per clock on com_data_in, framed by data_write_start / data_write_done.
- Decouples the slow host link from the controller's back-to-back shared-memory write phase.

---
 rtl/word_burst_loader.sv | 174 +++++++++++++++++
 tb/tb_word_burst_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_burst_loader.sv
// Buffers a serial byte stream into 16-bit words, then replays the block
// back-to-back to the controller framed by start/done pulses.
// Ports: clk, rst_n (async low); rx_data/rx_valid byte input; n_words block
// length; host_state (2'b11 = ready); com_data_in word stream;
// data_write_start/data_write_done pulses; busy; err (sticky).
// Optional build macro LOADER_CHECKSUM_EN: a trailing two's-complement
// checksum word must cancel the payload sum, else the block is rejected.
module word_burst_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int LEAD  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic [AW:0]   n_words,
  input  logic [1:0]    host_state,
  output logic [15:0]   com_data_in,
  output logic          data_write_start,
  output logic          data_write_done,
  output logic          busy,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_LEAD  = 3'd3;
  localparam logic [2:0] S_BURST = 3'd4;

  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  localparam logic [1:0]  LEAD_W  = LEAD[1:0];
  localparam logic [1:0]  HOST_RDY = 2'b11;

  logic [2:0]  r_state;
  logic [AW:0] r_nw;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_lo;
  logic        r_hi_next;
  logic [1:0]  r_lcnt;
  logic [15:0] r_dout;
  logic        r_start;
  logic        r_err;
  logic [15:0] r_mem [DEPTH];

  logic [15:0] w_word;
  logic [AW:0] w_wr_next;
  logic [AW:0] w_rd_next;
  logic        w_last;
  logic        w_we;
  logic        w_nw_bad;
  logic        w_payload;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [15:0] w_sum_next;
  assign w_sum_next = r_sum + w_word;
  // Once nw words are stored the next word is the checksum, not payload.
  assign w_payload  = (r_wr_ptr != r_nw);
`else
  assign w_payload  = 1'b1;
`endif

  assign w_word    = {rx_data, r_lo};
  assign w_wr_next = r_wr_ptr + ONE;
  assign w_rd_next = r_rd_ptr + ONE;
  assign w_nw_bad  = (n_words == '0) || (n_words > DEPTH_W);
  assign w_last    = (r_state == S_BURST) && (r_rd_ptr == r_nw - ONE);
  assign w_we      = (r_state == S_FILL) && rx_valid
                     && r_hi_next && w_payload;

  assign com_data_in      = r_dout;
  assign data_write_start = r_start;
  assign data_write_done  = w_last;
  assign busy             = (r_state != S_IDLE);
  assign err              = r_err;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_nw      <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_lo      <= '0;
      r_hi_next <= 1'b0;
      r_lcnt    <= '0;
      r_dout    <= '0;
      r_start   <= 1'b0;
      r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            if (w_nw_bad) begin
              r_err <= 1'b1;
            end else begin
              r_nw      <= n_words;
              r_lo      <= rx_data;
              r_hi_next <= 1'b1;
              r_wr_ptr  <= '0;
`ifdef LOADER_CHECKSUM_EN
              r_sum     <= '0;
`endif
              r_state   <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (rx_valid) begin
            if (!r_hi_next) begin
              r_lo      <= rx_data;
              r_hi_next <= 1'b1;
            end else begin
              r_hi_next <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
              if (w_payload) begin
                r_sum    <= w_sum_next;
                r_wr_ptr <= w_wr_next;
              end else if (w_sum_next == 16'h0000) begin
                r_state  <= S_ARM;
              end else begin
                r_err    <= 1'b1;
                r_state  <= S_IDLE;
              end
`else
              r_wr_ptr <= w_wr_next;
              if (w_wr_next == r_nw) r_state <= S_ARM;
`endif
            end
          end
        end
        S_ARM: begin
          if (rx_valid) r_err <= 1'b1;
          if (host_state == HOST_RDY) begin
            r_start  <= 1'b1;
            r_rd_ptr <= '0;
            r_lcnt   <= 2'd1;
            // Word 0 is presented through the whole lead-in.
            r_dout   <= r_mem[{AW{1'b0}}];
            r_state  <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (rx_valid) r_err <= 1'b1;
          if (r_lcnt == LEAD_W) r_state <= S_BURST;
          else                  r_lcnt  <= r_lcnt + 2'd1;
        end
        S_BURST: begin
          if (rx_valid) r_err <= 1'b1;
          if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            // Fetch the next word now so it lands with no bubble.
            r_rd_ptr <= w_rd_next;
            r_dout   <= r_mem[w_rd_next[AW-1:0]];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_burst_loader.sv
// Directed bench for word_burst_loader: table-driven blocks plus
// hold-off, full-depth, error, single-word/reset and checksum sequences.
module tb_word_burst_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LEAD  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [AW:0]   n_words = '0;
  logic [1:0]    host_state = '0;
  logic [15:0]   com_data_in;
  logic          data_write_start;
  logic          data_write_done;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  word_burst_loader #(.DEPTH(DEPTH), .AW(AW), .LEAD(LEAD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .n_words          (n_words),
    .host_state       (host_state),
    .com_data_in      (com_data_in),
    .data_write_start (data_write_start),
    .data_write_done  (data_write_done),
    .busy             (busy),
    .err              (err)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int idx = 0;
  int done_idx = 0;
  int both_hi = 0;
  int stray_done = 0;
  bit coll = 1'b0;
  logic [15:0] lead_val = '0;
  logic [15:0] got [0:1099];
  logic [15:0] blk [0:1023];

  typedef struct {
    int              n;
    logic [3:0][15:0] w;
  } vec_t;
  vec_t vecs [4];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      coll = 1'b0;
    end else begin
      if (data_write_start) begin
        start_cnt++;
        start_cyc = cyc;
        coll = 1'b1;
        idx = 0;
        if (data_write_done) both_hi++;
      end
      if (coll && cyc == start_cyc + LEAD - 1) lead_val = com_data_in;
      if (coll && cyc >= start_cyc + LEAD) begin
        if (idx < 1100) got[idx] = com_data_in;
        idx++;
        if (data_write_done) begin
          done_cnt++;
          done_idx = idx;
          coll = 1'b0;
        end
      end else if (data_write_done) begin
        done_cnt++;
        stray_done++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic send_blk(input int n);
    logic [15:0] s;
    s = '0;
    n_words = n[AW:0];
    for (int i = 0; i < n; i++) begin
      send_word(blk[i]);
      s = s + blk[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(16'h0000 - s);
`endif
  endtask

  task automatic wait_start(input int s0, input int lim);
    for (int i = 0; i < lim && start_cnt == s0; i++) tick();
  endtask

  task automatic wait_done(input int d0, input int lim);
    for (int i = 0; i < lim && done_cnt == d0; i++) tick();
  endtask

  task automatic run_block(input string tag, input int n);
    int s0;
    int d0;
    s0 = start_cnt;
    d0 = done_cnt;
    send_blk(n);
    wait_done(d0, n + 40);
    chk({tag, "_starts"}, start_cnt - s0, 1);
    chk({tag, "_dones"}, done_cnt - d0, 1);
    chk({tag, "_done_idx"}, done_idx, n);
    chk({tag, "_lead_val"}, int'(lead_val), int'(blk[0]));
    for (int i = 0; i < n && i < 4; i++)
      chk($sformatf("%s_w%0d", tag, i), int'(got[i]), int'(blk[i]));
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    int s0;
    int d0;
    int c0;
    int bad;

    vecs[0].n = 4;
    vecs[0].w = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    vecs[1].n = 1;
    vecs[1].w = {16'h0000, 16'h0000, 16'h0000, 16'hA5C3};
    vecs[2].n = 2;
    vecs[2].w = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[3].n = 3;
    vecs[3].w = {16'h0000, 16'h7FFF, 16'h8000, 16'h0001};

    rst_n = 1'b0;
    #1;
    chk("rst_dout", int'(com_data_in), 0);
    chk("rst_start", int'(data_write_start), 0);
    chk("rst_done", int'(data_write_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      host_state = 2'b11;
      for (int i = 0; i < vecs[v].n; i++) blk[i] = vecs[v].w[i];
      run_block($sformatf("vec%0d", v), vecs[v].n);
    end

    do_reset();
    host_state = 2'b01;
    blk[0] = 16'hCAFE;
    blk[1] = 16'hBEEF;
    s0 = start_cnt;
    d0 = done_cnt;
    send_blk(2);
    repeat (50) tick();
    chk("hold_no_start", start_cnt - s0, 0);
    chk("hold_busy", int'(busy), 1);
    host_state = 2'b11;
    c0 = cyc;
    wait_start(s0, 10);
    chk("hold_start_cyc", start_cyc, c0 + 2);
    wait_done(d0, 20);
    chk("hold_w0", int'(got[0]), 16'hCAFE);
    chk("hold_w1", int'(got[1]), 16'hBEEF);
    chk("hold_done_idx", done_idx, 2);

    do_reset();
    host_state = 2'b11;
    for (int i = 0; i < DEPTH; i++) blk[i] = 16'(i);
    s0 = start_cnt;
    d0 = done_cnt;
    send_blk(DEPTH);
    wait_done(d0, DEPTH + 40);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (got[i] !== blk[i]) bad++;
    chk("full_bad_words", bad, 0);
    chk("full_done_idx", done_idx, DEPTH);
    chk("full_last", int'(got[DEPTH-1]), 16'h03FF);
    chk("full_starts", start_cnt - s0, 1);
    chk("full_dones", done_cnt - d0, 1);

    do_reset();
    n_words = '0;
    send_byte(8'h11);
    tick();
    chk("nw0_err", int'(err), 1);
    chk("nw0_busy", int'(busy), 0);
    do_reset();
    chk("err_cleared", int'(err), 0);
    n_words = 11'd1025;
    send_byte(8'h22);
    tick();
    chk("nw1025_err", int'(err), 1);
    chk("nw1025_busy", int'(busy), 0);

    do_reset();
    host_state = 2'b11;
    blk[0] = 16'h0102;
    blk[1] = 16'h0304;
    blk[2] = 16'h0506;
    blk[3] = 16'h0708;
    s0 = start_cnt;
    d0 = done_cnt;
    send_blk(4);
    wait_start(s0, 10);
    tick();
    send_byte(8'h77);
    wait_done(d0, 20);
    chk("burst_byte_err", int'(err), 1);
    chk("burst_w0", int'(got[0]), 16'h0102);
    chk("burst_w3", int'(got[3]), 16'h0708);
    chk("burst_done_idx", done_idx, 4);

    do_reset();
    host_state = 2'b11;
    blk[0] = 16'h55AA;
    run_block("single", 1);
    blk[0] = 16'h1111;
    blk[1] = 16'h2222;
    blk[2] = 16'h3333;
    blk[3] = 16'h4444;
    s0 = start_cnt;
    d0 = done_cnt;
    send_blk(4);
    wait_start(s0, 10);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", int'(com_data_in), 0);
    chk("mid_rst_done", int'(data_write_done), 0);
    chk("mid_rst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_dout_held", int'(com_data_in), 0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    host_state = 2'b11;
    s0 = start_cnt;
    d0 = done_cnt;
    n_words = 11'd2;
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'hFFFD);
    wait_done(d0, 20);
    chk("cs_ok_dones", done_cnt - d0, 1);
    chk("cs_ok_w0", int'(got[0]), 1);
    chk("cs_ok_w1", int'(got[1]), 2);
    chk("cs_ok_err", int'(err), 0);
    do_reset();
    s0 = start_cnt;
    n_words = 11'd2;
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'hFFFE);
    repeat (20) tick();
    chk("cs_bad_start", start_cnt - s0, 0);
    chk("cs_bad_err", int'(err), 1);
    chk("cs_bad_busy", int'(busy), 0);
`endif

    chk("start_done_overlap", both_hi, 0);
    chk("stray_done", stray_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
